i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
Serialises the 16-bit stereo audio produced by the core into a Philips-standard I2S stream for the onboard DAC/amplifier (hp_bck/hp_ws/hp_din).
- Replaces the ad-hoc divider, mono mix and shift logic in the board top levels with one reusable stage.
- Sits directly downstream of the core's audio output, in the clk32 domain.
- Supports true stereo or a saturating mono mix, and signed or offset-binary output.

Parameters:
CLK_HZ, 32000000, system clock frequency in Hz.
SAMPLE_HZ, 24000, target sample rate; the actual rate is set by integer division.
WIDTH, 16, bits per channel slot; a frame is 2*WIDTH bit clocks.
MONO, 0, 1 = both slots carry sat(audio_l+audio_r); 0 = independent L/R.
OFFSET_BIN, 0, 1 = invert the MSB of each transmitted word (adds 0x8000 for WIDTH=16).

Ports:
clk32  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
en  in  1  stream enable (tie to !por); low = idle, outputs 0.
audio_l  in  WIDTH  left sample, signed two's complement; sampled only at frame start.
audio_r  in  WIDTH  right sample, signed two's complement; sampled only at frame start.
sample_stb  out  1  one-clk32 pulse when a new L/R pair is latched.
i2s_bck  out  1  bit clock.
i2s_ws  out  1  word select (0 = left).
i2s_din  out  1  serial data, MSB first.

Behaviour:
- HALF = CLK_HZ/(SAMPLE_HZ*4*WIDTH), integer division; elaboration error if HALF<2. Default HALF=20, giving BCK=800 kHz and 1280 clk32 per frame (25 kHz).
- Reset (async, reset_n=0): div_cnt=0, slot=0, bck=0, ws=0, din=0, sample_stb=0, shift registers cleared.
- Idle: en=0, sampled synchronously, forces the same state as reset. This applies mid-frame too, with no frame completion.
- Start: on the first clk32 with en=1 while idle:
  - latch the sample pair, pulse sample_stb, slot=0;
  - drive din = MSB of left word; bck stays 0;
  - start div_cnt.
- Divider: div_cnt counts 0..HALF-1. At HALF-1 it wraps to 0 and bck toggles.
- Rising event (bck 0->1): no data change. The receiver samples on this edge.
- Falling event (bck 1->0): slot advances; din and ws update in the same clk32 cycle as bck falls.
  - Slot wraps 2*WIDTH-1 -> 0.
  - On wrap: latch a new pair, pulse sample_stb, load MSB.
- Data per slot s:
  - s<WIDTH: left[WIDTH-1-s];
  - s>=WIDTH: right[2*WIDTH-1-s].
- Word select is one bit early (I2S): ws=1 for slots WIDTH-1 .. 2*WIDTH-2, else 0.
- Latching:
  - The pair is captured into L/R holding registers at frame start only.
  - Input changes mid-frame do not affect the current frame.
- MONO=1: word = clamp(sext(l)+sext(r), -2^(WIDTH-1), 2^(WIDTH-1)-1), computed at latch time with a WIDTH+1 bit sum. The same word goes in both slots.
- OFFSET_BIN=1: MSB inverted after mixing/saturation.
- sample_stb is exactly 1 clk32 wide; period = 2*HALF*2*WIDTH clocks.

Decomposition:
- Package audio_pkg holds:
  - typedef sample_t (logic signed [15:0]);
  - function sat_add(sample_t, sample_t) returning sample_t;
  - localparam I2S_SLOTS=2*WIDTH.
- One natural sub-module, i2s_bck_gen: divider plus bck register, emitting rise_evt/fall_evt one-clk strobes.
- Slot counter, latch and shift logic stay in i2s_audio_tx.

Test Plan:
- Reset/idle: hold reset_n=0 and then en=0 for 2000 clks -> bck=ws=din=sample_stb=0 throughout.
- Stereo frame: en=1, L=16'hA5C3, R=16'h3C5A. Capture din on 32 bck rising edges -> A5C3 in slots 0..15, 3C5A in slots 16..31. ws rises at slot 15 and falls at slot 31. BCK period = 40 clks.
- Frame timing: count clk32 between sample_stb pulses -> exactly 1280. Change inputs mid-frame -> the current frame is unchanged; the new value appears in the next frame.
- Mono saturation: MONO=1, L=16'h7000, R=16'h2000 -> both slots 16'h7FFF. L=16'h8000, R=16'hFFFF -> 16'h8000. L=16'h0100, R=16'hFF00 -> 16'h0000.
- Offset binary: OFFSET_BIN=1, L=16'h0000 -> 16'h8000 transmitted; L=16'hFFFF -> 16'h7FFF.
- Abort mid-frame: drop en at slot 9 -> all outputs 0 within 1 clk. Re-assert en -> sample_stb on the first en clk; slot-0 MSB valid before the first rising bck. Repeat the abort by pulsing reset_n low instead.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and the saturating stereo mix used by the I2S stage.
package audio_pkg;

    localparam int AUDIO_W   = 16;
    localparam int I2S_SLOTS = 2 * AUDIO_W;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    function automatic sample_t sat_add(sample_t a, sample_t b);
        logic signed [AUDIO_W:0] s;
        s = {a[AUDIO_W-1], a} + {b[AUDIO_W-1], b};
        if (s[AUDIO_W] != s[AUDIO_W-1]) begin
            if (s[AUDIO_W])
                return {1'b1, {(AUDIO_W-1){1'b0}}};
            return {1'b0, {(AUDIO_W-1){1'b1}}};
        end
        return s[AUDIO_W-1:0];
    endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: toggles bck every HALF clocks while running and
// flags the clock cycle in which bck rises or falls.
module i2s_bck_gen #(
    parameter int HALF = 20
) (
    input  logic clk32,
    input  logic reset_n,
    input  logic run_i,
    output logic bck_o,
    output logic rise_evt_o,
    output logic fall_evt_o
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] div_q, div_d;
    logic          bck_q, bck_d;
    logic          wrap;

    assign wrap       = run_i && (div_q == LAST);
    assign rise_evt_o = wrap && !bck_q;
    assign fall_evt_o = wrap && bck_q;
    assign bck_o      = bck_q;

    always_comb begin
        div_d = '0;
        bck_d = 1'b0;
        if (run_i) begin
            div_d = wrap ? '0 : div_q + 1'b1;
            bck_d = bck_q ^ wrap;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bck_q <= bck_d;
        end
    end

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter: latches one L/R pair per frame and shifts it
// out MSB first, with optional saturating mono mix and offset binary.
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int CLK_HZ     = 32000000,
    parameter int SAMPLE_HZ  = 24000,
    parameter int WIDTH      = 16,
    parameter int MONO       = 0,
    parameter int OFFSET_BIN = 0
) (
    input  logic             clk32,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] audio_l,
    input  logic [WIDTH-1:0] audio_r,
    output logic             sample_stb,
    output logic             i2s_bck,
    output logic             i2s_ws,
    output logic             i2s_din
);

    localparam int HALF  = CLK_HZ / (SAMPLE_HZ * 4 * WIDTH);
    localparam int SLOTS = 2 * WIDTH;
    localparam int SW    = $clog2(SLOTS);
    localparam logic [WIDTH-1:0] MSB_M = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] OFF_M = (OFFSET_BIN != 0) ? MSB_M : '0;

    if (HALF < 2) begin : g_bad_half
        $error("i2s_audio_tx: HALF must be at least 2");
    end

    logic [WIDTH-1:0] mix_w, word_l, word_r;

    if (WIDTH == AUDIO_W) begin : g_mix_pkg
        assign mix_w = sat_add(audio_l, audio_r);
    end else begin : g_mix_gen
        logic [WIDTH:0] sum;
        assign sum   = {audio_l[WIDTH-1], audio_l} + {audio_r[WIDTH-1], audio_r};
        assign mix_w = (sum[WIDTH] != sum[WIDTH-1])
                     ? {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}}
                     : sum[WIDTH-1:0];
    end

    assign word_l = ((MONO != 0) ? mix_w : audio_l) ^ OFF_M;
    assign word_r = ((MONO != 0) ? mix_w : audio_r) ^ OFF_M;

    logic             run_q, run_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [SLOTS-1:0] sh_q, sh_d;
    logic             ws_q, ws_d;
    logic             stb_q, stb_d;
    logic             fall_evt;
    logic             rise_unused;

    i2s_bck_gen #(
        .HALF(HALF)
    ) u_bck (
        .clk32     (clk32),
        .reset_n   (reset_n),
        .run_i     (en && run_q),
        .bck_o     (i2s_bck),
        .rise_evt_o(rise_unused),
        .fall_evt_o(fall_evt)
    );

    always_comb begin
        run_d  = run_q;
        slot_d = slot_q;
        sh_d   = sh_q;
        ws_d   = ws_q;
        stb_d  = 1'b0;
        if (!en) begin
            run_d  = 1'b0;
            slot_d = '0;
            sh_d   = '0;
            ws_d   = 1'b0;
        end else if (!run_q || (fall_evt && slot_q == SW'(SLOTS - 1))) begin
            run_d  = 1'b1;
            slot_d = '0;
            sh_d   = {word_l, word_r};
            ws_d   = 1'b0;
            stb_d  = 1'b1;
        end else if (fall_evt) begin
            slot_d = slot_q + 1'b1;
            sh_d   = {sh_q[SLOTS-2:0], 1'b0};
            // ws leads the data by one slot
            ws_d   = (slot_d >= SW'(WIDTH - 1)) && (slot_d <= SW'(SLOTS - 2));
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            run_q  <= 1'b0;
            slot_q <= '0;
            sh_q   <= '0;
            ws_q   <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            slot_q <= slot_d;
            sh_q   <= sh_d;
            ws_q   <= ws_d;
            stb_q  <= stb_d;
        end
    end

    assign sample_stb = stb_q;
    assign i2s_ws     = ws_q;
    assign i2s_din    = sh_q[SLOTS-1];

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed-plus-random bench for i2s_audio_tx: stereo, mono and
// offset-binary builds run side by side against an arithmetic model.
module tb_i2s_audio_tx;

    logic        clk32 = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] audio_l = '0;
    logic [15:0] audio_r = '0;
    logic        stb[3], bck[3], ws[3], din[3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wide = 0;
    logic stb_prev = 1'b0;
    int last_stb = 0;
    int last_gap = 0;

    always #5 clk32 = ~clk32;

    always @(posedge clk32) cyc <= cyc + 1;

    always @(negedge clk32) begin
        if (stb[0] && stb_prev) wide <= wide + 1;
        stb_prev <= stb[0];
    end

    i2s_audio_tx #(.MONO(0), .OFFSET_BIN(0)) u_st (
        .clk32(clk32), .reset_n(reset_n), .en(en),
        .audio_l(audio_l), .audio_r(audio_r),
        .sample_stb(stb[0]), .i2s_bck(bck[0]),
        .i2s_ws(ws[0]), .i2s_din(din[0]));

    i2s_audio_tx #(.MONO(1), .OFFSET_BIN(0)) u_mono (
        .clk32(clk32), .reset_n(reset_n), .en(en),
        .audio_l(audio_l), .audio_r(audio_r),
        .sample_stb(stb[1]), .i2s_bck(bck[1]),
        .i2s_ws(ws[1]), .i2s_din(din[1]));

    i2s_audio_tx #(.MONO(0), .OFFSET_BIN(1)) u_off (
        .clk32(clk32), .reset_n(reset_n), .en(en),
        .audio_l(audio_l), .audio_r(audio_r),
        .sample_stb(stb[2]), .i2s_bck(bck[2]),
        .i2s_ws(ws[2]), .i2s_din(din[2]));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0 = stereo, 1 = saturating mono, 2 = offset binary stereo
    function automatic logic [31:0] model(int mode, logic [15:0] l,
                                          logic [15:0] r);
        int s;
        logic [15:0] m, ol, orr;
        if (mode == 0) return {l, r};
        if (mode == 1) begin
            s = int'($signed(l)) + int'($signed(r));
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            m = 16'(s);
            return {m, m};
        end
        ol  = 16'((int'(l) + 32768) % 65536);
        orr = 16'((int'(r) + 32768) % 65536);
        return {ol, orr};
    endfunction

    function automatic bit all_zero();
        bit z = 1'b1;
        for (int i = 0; i < 3; i++)
            if ({stb[i], bck[i], ws[i], din[i]} !== 4'b0) z = 1'b0;
        return z;
    endfunction

    task automatic wait_stb(output int waited);
        waited = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk32);
            if (stb[0]) begin
                waited   = i + 1;
                last_gap = cyc - last_stb;
                last_stb = cyc;
                return;
            end
        end
    endtask

    task automatic capture(input logic [15:0] nl, input logic [15:0] nr,
                           input int chg, input int stop,
                           output logic [31:0] f0, output logic [31:0] f1,
                           output logic [31:0] f2, output logic [31:0] wsv,
                           output int n, output int bper);
        logic p;
        int t0;
        f0 = '0; f1 = '0; f2 = '0; wsv = '0;
        n = 0; bper = 0; t0 = 0;
        p = bck[0];
        for (int i = 0; i < 3000 && n < stop; i++) begin
            @(negedge clk32);
            if (!p && bck[0]) begin
                f0  = {f0[30:0], din[0]};
                f1  = {f1[30:0], din[1]};
                f2  = {f2[30:0], din[2]};
                wsv = {wsv[30:0], ws[0]};
                if (n == 0) t0 = cyc;
                if (n == 1) bper = cyc - t0;
                if (n == chg) begin
                    audio_l = nl;
                    audio_r = nr;
                end
                n++;
            end
            p = bck[0];
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] l,
                               input logic [15:0] r, input int n,
                               input logic [31:0] f0, input logic [31:0] f1,
                               input logic [31:0] f2);
        chk({tag, "_bits"}, n, 32);
        chk({tag, "_stereo"}, f0, model(0, l, r));
        chk({tag, "_mono"}, f1, model(1, l, r));
        chk({tag, "_offset"}, f2, model(2, l, r));
    endtask

    task automatic check_start(input string tag, input logic [15:0] l,
                               input logic [15:0] r);
        int w;
        logic [31:0] e0, e1, e2;
        e0 = model(0, l, r);
        e1 = model(1, l, r);
        e2 = model(2, l, r);
        wait_stb(w);
        chk({tag, "_stb_lat"}, w, 1);
        chk({tag, "_bck0"}, {bck[0], bck[1], bck[2]}, 3'b000);
        chk({tag, "_msb"}, {din[0], din[1], din[2]},
            {e0[31], e1[31], e2[31]});
    endtask

    localparam int NF = 12;
    logic [15:0] vl[NF+1];
    logic [15:0] vr[NF+1];
    logic [31:0] ews, f0, f1, f2, wsv;
    int n, bper, w, bad;

    initial begin
        ews = '0;
        for (int s = 0; s < 32; s++)
            ews[31-s] = (s >= 15 && s <= 30);

        vl[0] = 16'hA5C3; vr[0] = 16'h3C5A;
        vl[1] = 16'h7000; vr[1] = 16'h2000;
        vl[2] = 16'h8000; vr[2] = 16'hFFFF;
        vl[3] = 16'h0100; vr[3] = 16'hFF00;
        vl[4] = 16'h0000; vr[4] = 16'h0000;
        vl[5] = 16'hFFFF; vr[5] = 16'hFFFF;
        for (int k = 6; k <= NF; k++) begin
            vl[k] = 16'($urandom());
            vr[k] = 16'($urandom());
        end

        bad = 0;
        repeat (50) begin
            @(negedge clk32);
            if (!all_zero()) bad++;
        end
        reset_n = 1'b1;
        repeat (2000) begin
            @(negedge clk32);
            if (!all_zero()) bad++;
        end
        chk("reset_idle", bad, 0);

        audio_l = vl[0];
        audio_r = vr[0];
        en = 1'b1;
        check_start("start", vl[0], vr[0]);

        for (int k = 0; k < NF; k++) begin
            capture(vl[k+1], vr[k+1], 1 + (k * 7) % 30, 32,
                    f0, f1, f2, wsv, n, bper);
            check_frame($sformatf("frame%0d", k), vl[k], vr[k],
                        n, f0, f1, f2);
            if (k == 0) begin
                chk("ws_pattern", wsv, ews);
                chk("bck_period", bper, 40);
            end
            wait_stb(w);
            chk($sformatf("period%0d", k), last_gap, 1280);
        end

        capture(vl[NF], vr[NF], 99, 10, f0, f1, f2, wsv, n, bper);
        chk("abort_slot", n, 10);
        en = 1'b0;
        @(negedge clk32);
        chk("abort_zero", all_zero(), 1);
        bad = 0;
        repeat (30) begin
            @(negedge clk32);
            if (!all_zero()) bad++;
        end
        chk("abort_idle", bad, 0);
        audio_l = 16'h5A0F;
        audio_r = 16'h9137;
        en = 1'b1;
        check_start("restart", 16'h5A0F, 16'h9137);
        capture(16'h5A0F, 16'h9137, 99, 32, f0, f1, f2, wsv, n, bper);
        check_frame("restart", 16'h5A0F, 16'h9137, n, f0, f1, f2);
        wait_stb(w);
        chk("restart_period", last_gap, 1280);

        capture(16'h0F0F, 16'hF00F, 99, 10, f0, f1, f2, wsv, n, bper);
        chk("rst_abort_slot", n, 10);
        reset_n = 1'b0;
        #1;
        chk("rst_abort_zero", all_zero(), 1);
        @(negedge clk32);
        chk("rst_hold_zero", all_zero(), 1);
        audio_l = 16'h8001;
        audio_r = 16'h7FFE;
        reset_n = 1'b1;
        check_start("rst_restart", 16'h8001, 16'h7FFE);
        capture(16'h0, 16'h0, 99, 32, f0, f1, f2, wsv, n, bper);
        check_frame("rst_restart", 16'h8001, 16'h7FFE, n, f0, f1, f2);
        @(negedge clk32);

        chk("stb_width", wide, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
